pcie_fc_monitor: RTL and testbench

PCIE_FC_MONITOR -- requirements
Module: pcie_fc_monitor

---
 rtl/pcie_fc_monitor_if.sv | 38 +++
 rtl/pcie_fc_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_pcie_fc_monitor.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_fc_monitor_if.sv
// Flow-control monitor bus: PCIe core credit inputs, credit select,
// scan control/status and the register read port.
interface pcie_fc_monitor_if;
    logic        enable;
    logic        clear;
    logic [7:0]  cfg_fc_ph;
    logic [7:0]  cfg_fc_nph;
    logic [7:0]  cfg_fc_cplh;
    logic [11:0] cfg_fc_pd;
    logic [11:0] cfg_fc_npd;
    logic [11:0] cfg_fc_cpld;
    logic [2:0]  cfg_fc_sel;
    logic [7:0]  reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;
    logic        busy;

    // Host / PCIe-core side
    modport master (
        output enable, clear,
        output cfg_fc_ph, cfg_fc_nph, cfg_fc_cplh,
        output cfg_fc_pd, cfg_fc_npd, cfg_fc_cpld,
        input  cfg_fc_sel,
        output reg_rd_addr, reg_rd_en,
        input  reg_rd_data, reg_rd_valid, busy
    );

    // Monitor side
    modport slave (
        input  enable, clear,
        input  cfg_fc_ph, cfg_fc_nph, cfg_fc_cplh,
        input  cfg_fc_pd, cfg_fc_npd, cfg_fc_cpld,
        output cfg_fc_sel,
        input  reg_rd_addr, reg_rd_en,
        output reg_rd_data, reg_rd_valid, busy
    );
endinterface

// File: rtl/pcie_fc_monitor.sv
// PCIe flow-control credit monitor: steps cfg_fc_sel through the credit
// types, lets each settle, snapshots the six credit counters, tracks the
// minimum seen on select 0 and exposes everything through a read port.
module pcie_fc_monitor #(
    parameter int unsigned SEL_COUNT     = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    pcie_fc_monitor_if.slave bus
);

    localparam logic [2:0] LP_LAST_SEL = 3'(SEL_COUNT - 1);
    localparam logic [7:0] LP_RELOAD   = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_sel, w_sel_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;

    logic        w_capture;
    logic        w_cap_first;
    logic        w_cap_last;

    // Eight slots always exist; slots at or above SEL_COUNT are never written.
    logic [7:0]  r_snap_ph   [8];
    logic [11:0] r_snap_pd   [8];
    logic [7:0]  r_snap_nph  [8];
    logic [11:0] r_snap_npd  [8];
    logic [7:0]  r_snap_cplh [8];
    logic [11:0] r_snap_cpld [8];

    logic [7:0]  r_min_ph, r_min_nph, r_min_cplh;
    logic [11:0] r_min_pd, r_min_npd, r_min_cpld;
    logic [31:0] r_scan_count;

    logic [2:0]  w_slot;
    logic [2:0]  w_field;
    logic [31:0] w_rd_mux;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;

    assign w_capture   = (r_state == ST_CAPTURE);
    assign w_cap_first = w_capture && (r_sel == 3'd0);
    assign w_cap_last  = w_capture && (r_sel == LP_LAST_SEL);

    // FSM state, select and settle counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next-state: settle countdown, capture, advance select
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_sel_nxt = '0;
                if (bus.enable) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = LP_RELOAD;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_CAPTURE: begin
                w_cnt_nxt = LP_RELOAD;
                if (r_sel == LP_LAST_SEL) begin
                    w_sel_nxt   = '0;
                    w_state_nxt = bus.enable ? ST_SETTLE : ST_IDLE;
                end else begin
                    w_sel_nxt   = r_sel + 3'd1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    // Snapshot write for the current select; unaffected by clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_snap_ph[i]   <= '0;
                r_snap_pd[i]   <= '0;
                r_snap_nph[i]  <= '0;
                r_snap_npd[i]  <= '0;
                r_snap_cplh[i] <= '0;
                r_snap_cpld[i] <= '0;
            end
        end else if (w_capture) begin
            r_snap_ph[r_sel]   <= bus.cfg_fc_ph;
            r_snap_pd[r_sel]   <= bus.cfg_fc_pd;
            r_snap_nph[r_sel]  <= bus.cfg_fc_nph;
            r_snap_npd[r_sel]  <= bus.cfg_fc_npd;
            r_snap_cplh[r_sel] <= bus.cfg_fc_cplh;
            r_snap_cpld[r_sel] <= bus.cfg_fc_cpld;
        end
    end

    // Minimum trackers and scan counter; clear takes priority over updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_ph     <= '1;
            r_min_pd     <= '1;
            r_min_nph    <= '1;
            r_min_npd    <= '1;
            r_min_cplh   <= '1;
            r_min_cpld   <= '1;
            r_scan_count <= '0;
        end else if (bus.clear) begin
            r_min_ph     <= '1;
            r_min_pd     <= '1;
            r_min_nph    <= '1;
            r_min_npd    <= '1;
            r_min_cplh   <= '1;
            r_min_cpld   <= '1;
            r_scan_count <= '0;
        end else begin
            if (w_cap_first) begin
                r_min_ph   <= (bus.cfg_fc_ph   < r_min_ph)   ? bus.cfg_fc_ph   : r_min_ph;
                r_min_pd   <= (bus.cfg_fc_pd   < r_min_pd)   ? bus.cfg_fc_pd   : r_min_pd;
                r_min_nph  <= (bus.cfg_fc_nph  < r_min_nph)  ? bus.cfg_fc_nph  : r_min_nph;
                r_min_npd  <= (bus.cfg_fc_npd  < r_min_npd)  ? bus.cfg_fc_npd  : r_min_npd;
                r_min_cplh <= (bus.cfg_fc_cplh < r_min_cplh) ? bus.cfg_fc_cplh : r_min_cplh;
                r_min_cpld <= (bus.cfg_fc_cpld < r_min_cpld) ? bus.cfg_fc_cpld : r_min_cpld;
            end
            if (w_cap_last) begin
                r_scan_count <= r_scan_count + 32'd1;
            end
        end
    end

    assign w_slot  = bus.reg_rd_addr[5:3];
    assign w_field = bus.reg_rd_addr[2:0];

    // Register map decode, zero-extending every field
    always_comb begin
        w_rd_mux = '0;
        if (bus.reg_rd_addr[7:6] == 2'b00) begin
            if (w_slot <= LP_LAST_SEL) begin
                case (w_field)
                    3'd0:    w_rd_mux = 32'(r_snap_ph[w_slot]);
                    3'd1:    w_rd_mux = 32'(r_snap_pd[w_slot]);
                    3'd2:    w_rd_mux = 32'(r_snap_nph[w_slot]);
                    3'd3:    w_rd_mux = 32'(r_snap_npd[w_slot]);
                    3'd4:    w_rd_mux = 32'(r_snap_cplh[w_slot]);
                    3'd5:    w_rd_mux = 32'(r_snap_cpld[w_slot]);
                    default: w_rd_mux = '0;
                endcase
            end
        end else begin
            case (bus.reg_rd_addr)
                8'h40:   w_rd_mux = 32'(r_min_ph);
                8'h41:   w_rd_mux = 32'(r_min_pd);
                8'h42:   w_rd_mux = 32'(r_min_nph);
                8'h43:   w_rd_mux = 32'(r_min_npd);
                8'h44:   w_rd_mux = 32'(r_min_cplh);
                8'h45:   w_rd_mux = 32'(r_min_cpld);
                8'h48:   w_rd_mux = r_scan_count;
                default: w_rd_mux = '0;
            endcase
        end
    end

    // Read port: one-cycle latency, data held between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.reg_rd_en;
            if (bus.reg_rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign bus.cfg_fc_sel   = r_sel;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.reg_rd_data  = r_rd_data;
    assign bus.reg_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_pcie_fc_monitor.sv
// Directed bench for pcie_fc_monitor (SEL_COUNT=4, SETTLE_CYCLES=4).
// A small core model drives each credit as base + cfg_fc_sel.
module tb_pcie_fc_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  b_ph   = 8'd40;
    logic [11:0] b_pd   = 12'h300;
    logic [7:0]  b_nph  = 8'd56;
    logic [11:0] b_npd  = 12'h500;
    logic [7:0]  b_cplh = 8'd72;
    logic [11:0] b_cpld = 12'h700;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [24];

    pcie_fc_monitor_if fc_if ();

    pcie_fc_monitor #(
        .SEL_COUNT     (4),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fc_if.slave)
    );

    always #5 clk = ~clk;

    // Credit counters respond to the select like the PCIe core would
    always_comb begin
        fc_if.cfg_fc_ph   = b_ph   + 8'(fc_if.cfg_fc_sel);
        fc_if.cfg_fc_pd   = b_pd   + 12'(fc_if.cfg_fc_sel);
        fc_if.cfg_fc_nph  = b_nph  + 8'(fc_if.cfg_fc_sel);
        fc_if.cfg_fc_npd  = b_npd  + 12'(fc_if.cfg_fc_sel);
        fc_if.cfg_fc_cplh = b_cplh + 8'(fc_if.cfg_fc_sel);
        fc_if.cfg_fc_cpld = b_cpld + 12'(fc_if.cfg_fc_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single read: strobe for one cycle, check the result the cycle after
    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
        fc_if.reg_rd_addr = addr;
        fc_if.reg_rd_en   = 1'b1;
        step();
        fc_if.reg_rd_en   = 1'b0;
        chk({name, "_valid"}, 32'(fc_if.reg_rd_valid), 32'd1);
        chk(name, fc_if.reg_rd_data, exp);
    endtask

    // Bounded wait for busy to fall; n is the number of edges taken
    task automatic wait_idle(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (fc_if.busy && n < 60);
    endtask

    initial begin
        int n;

        vecs[0]  = '{8'h00, 32'd25};
        vecs[1]  = '{8'h01, 32'h300};
        vecs[2]  = '{8'h02, 32'd56};
        vecs[3]  = '{8'h03, 32'h500};
        vecs[4]  = '{8'h04, 32'd72};
        vecs[5]  = '{8'h05, 32'h700};
        vecs[6]  = '{8'h06, 32'd0};
        vecs[7]  = '{8'h08, 32'd26};
        vecs[8]  = '{8'h09, 32'h301};
        vecs[9]  = '{8'h0C, 32'd73};
        vecs[10] = '{8'h18, 32'd28};
        vecs[11] = '{8'h1D, 32'h703};
        vecs[12] = '{8'h40, 32'd25};
        vecs[13] = '{8'h41, 32'h300};
        vecs[14] = '{8'h42, 32'd56};
        vecs[15] = '{8'h43, 32'h500};
        vecs[16] = '{8'h44, 32'd72};
        vecs[17] = '{8'h45, 32'h700};
        vecs[18] = '{8'h46, 32'd0};
        vecs[19] = '{8'h48, 32'd2};
        vecs[20] = '{8'h20, 32'd0};
        vecs[21] = '{8'h7F, 32'd0};
        vecs[22] = '{8'h3F, 32'd0};
        vecs[23] = '{8'h05, 32'h700};

        fc_if.enable      = 1'b0;
        fc_if.clear       = 1'b0;
        fc_if.reg_rd_addr = '0;
        fc_if.reg_rd_en   = 1'b0;

        // Reset values
        repeat (2) step();
        chk("rst_sel",   32'(fc_if.cfg_fc_sel),   32'd0);
        chk("rst_busy",  32'(fc_if.busy),         32'd0);
        chk("rst_valid", 32'(fc_if.reg_rd_valid), 32'd0);
        chk("rst_data",  fc_if.reg_rd_data,       32'd0);
        rst = 1'b0;
        step();
        rd(8'h40, 32'hFF,  "rst_min_ph");
        rd(8'h45, 32'hFFF, "rst_min_cpld");
        rd(8'h48, 32'd0,   "rst_count");
        rd(8'h00, 32'd0,   "rst_snap");

        // Scan timing: each select held 5 cycles, one scan = 20 cycles
        fc_if.enable = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            chk($sformatf("scan_sel_%0d", k), 32'(fc_if.cfg_fc_sel), 32'((k / 5) % 4));
            chk($sformatf("scan_busy_%0d", k), 32'(fc_if.busy), 32'd1);
        end
        rd(8'h48, 32'd1, "scan1_count");

        // Second scan sees a lower ph on select 0; enable drops during select 1
        b_ph = 8'd25;
        repeat (5) step();
        chk("drop_sel", 32'(fc_if.cfg_fc_sel), 32'd1);
        fc_if.enable = 1'b0;
        wait_idle(n);
        chk("drop_cycles", 32'(n), 32'd14);
        chk("drop_busy", 32'(fc_if.busy), 32'd0);
        chk("drop_sel0", 32'(fc_if.cfg_fc_sel), 32'd0);

        // Back-to-back register reads from the table
        for (int i = 0; i < 24; i++) begin
            fc_if.reg_rd_addr = vecs[i].addr;
            fc_if.reg_rd_en   = 1'b1;
            step();
            chk($sformatf("tbl_valid_%0d", i), 32'(fc_if.reg_rd_valid), 32'd1);
            chk($sformatf("tbl_data_%0h", vecs[i].addr), fc_if.reg_rd_data, vecs[i].exp);
        end
        fc_if.reg_rd_en = 1'b0;
        step();
        chk("hold_valid", 32'(fc_if.reg_rd_valid), 32'd0);
        chk("hold_data", fc_if.reg_rd_data, 32'h700);

        // Clear while idle
        fc_if.clear = 1'b1;
        step();
        fc_if.clear = 1'b0;
        rd(8'h40, 32'hFF,  "clr_min_ph");
        rd(8'h45, 32'hFFF, "clr_min_cpld");
        rd(8'h48, 32'd0,   "clr_count");
        rd(8'h00, 32'd25,  "clr_snap_kept");

        // Clear coinciding with the select-0 capture
        b_cpld = 12'h100;
        fc_if.enable = 1'b1;
        step();
        fc_if.enable = 1'b0;
        repeat (4) step();
        fc_if.clear = 1'b1;
        step();
        fc_if.clear = 1'b0;
        chk("col0_sel", 32'(fc_if.cfg_fc_sel), 32'd1);
        wait_idle(n);
        chk("col0_cycles", 32'(n), 32'd15);
        rd(8'h45, 32'hFFF, "col0_min_cpld");
        rd(8'h05, 32'h100, "col0_snap_cpld");
        rd(8'h40, 32'hFF,  "col0_min_ph");
        rd(8'h48, 32'd1,   "col0_count");

        // Clear coinciding with the last-select capture
        fc_if.enable = 1'b1;
        step();
        fc_if.enable = 1'b0;
        repeat (19) step();
        chk("colL_sel", 32'(fc_if.cfg_fc_sel), 32'd3);
        fc_if.clear = 1'b1;
        step();
        fc_if.clear = 1'b0;
        chk("colL_busy", 32'(fc_if.busy), 32'd0);
        rd(8'h48, 32'd0,   "colL_count");
        rd(8'h45, 32'hFFF, "colL_min_cpld");
        rd(8'h1D, 32'h103, "colL_snap_cpld");

        // Asynchronous reset in the middle of select 2 settling
        fc_if.enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (fc_if.cfg_fc_sel != 3'd2 && n < 60);
        chk("mrst_reach_sel2", 32'(fc_if.cfg_fc_sel), 32'd2);
        step();
        chk("mrst_busy_pre", 32'(fc_if.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_sel",  32'(fc_if.cfg_fc_sel),   32'd0);
        chk("mrst_busy", 32'(fc_if.busy),         32'd0);
        chk("mrst_data", fc_if.reg_rd_data,       32'd0);
        fc_if.enable = 1'b0;
        step();
        rst = 1'b0;
        rd(8'h40, 32'hFF,  "mrst_min_ph");
        rd(8'h45, 32'hFFF, "mrst_min_cpld");
        rd(8'h08, 32'd0,   "mrst_snap");
        chk("mrst_idle", 32'(fc_if.busy), 32'd0);

        // Leaves IDLE on the first edge with enable high
        fc_if.enable = 1'b1;
        step();
        chk("restart_busy", 32'(fc_if.busy), 32'd1);
        chk("restart_sel",  32'(fc_if.cfg_fc_sel), 32'd0);
        fc_if.enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
